fir3x_s2p: RTL and testbench
============================

FIR3X_S2P -- requirements
Module: fir3x_s2p

Interface
REQ-001 SHALL have parameter DW, default 32, sample width in bits (signed two's complement).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port s_data, input, DW, serial input sample.
REQ-005 SHALL have port s_valid, input, 1, s_data valid.
REQ-006 SHALL have port s_ready, output, 1, block can accept s_data this cycle.
REQ-007 SHALL have port flush, input, 1, single-cycle request to terminate the partial block.
REQ-008 SHALL have ports x3k, x3k1, x3k2, output, DW each, parallel block lanes for the 3x-unrolled FIR.
REQ-009 SHALL have port blk_valid, output, 1, lanes hold a valid block.
REQ-010 SHALL have port blk_ready, input, 1, downstream consumes block this cycle.
REQ-011 SHALL have port blk_flushed, output, 1, current block was zero-padded by flush.
REQ-012 SHALL have port fill, output, 2, samples staged in the partial block (0..2).

Function
REQ-013 SHALL accept a sample when s_valid && s_ready; handshakes without both SHALL change no state.
REQ-014 SHALL map samples in arrival order: 1st to x3k, 2nd to x3k1, 3rd to x3k2.
REQ-015 SHALL stage samples 1 and 2 in a collect register, fill incrementing 0->1->2.
REQ-016 SHALL, on the cycle the 3rd sample is accepted, load the output register with all 3 lanes, set blk_valid next cycle, return fill to 0 (latency 1 cycle from 3rd accept).
REQ-017 SHALL hold x3k/x3k1/x3k2/blk_flushed stable while blk_valid && !blk_ready.
REQ-018 SHALL clear blk_valid after blk_valid && blk_ready unless a new block loads that same cycle.
REQ-019 SHALL drive s_ready = !(fill==2 && blk_valid && !blk_ready) && !flush_pend; full throughput of 1 sample/cycle with blk_ready held high.
REQ-020 SHALL treat flush with fill==0 (after any same-cycle accept) as a no-op.
REQ-021 SHALL apply a same-cycle accepted sample before flush; if that sample completes the block, flush is a no-op.
REQ-022 SHALL pass lanes unmodified; no arithmetic, no width change.

Reset
REQ-023 SHALL on reset clear fill, flush_pend, blk_valid, blk_flushed and x3k/x3k1/x3k2 to 0 immediately, independent of clk.
REQ-024 SHALL discard any partial or unconsumed block on reset mid-operation; s_ready is 1 one cycle after reset deasserts.

Configuration
REQ-025 SHALL with FIR3X_FLUSH_PAD_EN defined: flush with fill>0 sets flush_pend; when the output register is free (or freed same cycle) the partial block loads with missing lanes 0, blk_flushed=1, fill=0, flush_pend=0.
REQ-026 SHALL without FIR3X_FLUSH_PAD_EN: flush with fill>0 clears fill next cycle, emits nothing; flush_pend is constant 0 and blk_flushed constant 0.

Structure
REQ-027 SHALL take DW default, lane count 3 and fill encoding from shared package fir3x_pkg.
REQ-028 SHALL place the output register with its valid/ready hold logic in one sub-module fir3x_blk_reg; collect/flush control stays in fir3x_s2p.

Verification
REQ-029 SHALL cover streaming: s_data 1,2,3,4,5,6 on consecutive cycles, blk_ready=1 -> block (1,2,3) one cycle after sample 3, block (4,5,6) one cycle after sample 6, s_ready never low.
REQ-030 SHALL cover backpressure: blk_ready=0, feed 1..5 -> block (1,2,3) held, fill=2, s_ready=0; raise blk_ready -> (1,2,3) consumed, s_ready=1, sample 6 yields (4,5,6).
REQ-031 SHALL cover flush with PAD_EN: feed 7,8, pulse flush -> block (7,8,0), blk_flushed=1, fill=0; without macro -> no block, fill=0.
REQ-032 SHALL cover simultaneous accept+flush: fill=2, s_data=9 with flush -> block (a,b,9), blk_flushed=0.
REQ-033 SHALL cover async reset mid-block: fill=1, blk_valid=1, assert reset between edges -> blk_valid, fill, lanes 0 immediately.
REQ-034 SHALL cover signed extremes: samples 0x80000000, 0x7FFFFFFF, 0xFFFFFFFF -> lanes bit-exact.

Source files
------------

// File: rtl/fir3x_pkg.sv
// Shared definitions for the 3x serial-to-parallel FIR front end.
// Holds the default sample width, the lane count and the fill-level encoding,
// plus a helper that advances the fill level by one accepted sample.
package fir3x_pkg;

  localparam int DW_DEF = 32;
  localparam int LANES  = 3;
  localparam int FILL_W = $clog2(LANES);

  // Samples staged in the partial block; a third sample never sits in the
  // collect register because it completes the block on the same edge.
  typedef enum logic [FILL_W-1:0] {
    FILL_0,
    FILL_1,
    FILL_2
  } fill_t;

  function automatic fill_t fill_next(input fill_t f);
    case (f)
      FILL_0:  fill_next = FILL_1;
      FILL_1:  fill_next = FILL_2;
      default: fill_next = FILL_0;
    endcase
  endfunction

endpackage

// File: rtl/fir3x_blk_reg.sv
// Output block register: holds one 3-lane block with valid/ready hold logic.
// Latency: 1 cycle from load to blk_valid; backpressure holds lanes while blk_valid && !blk_ready.
// Ports: load/ld_x0..ld_x2/ld_flushed (load side, only pulsed when free), free (register
//        empty or being consumed this cycle), x3k/x3k1/x3k2/blk_valid/blk_ready/blk_flushed (out).
module fir3x_blk_reg
  import fir3x_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] ld_x0,
  input  logic [DW-1:0] ld_x1,
  input  logic [DW-1:0] ld_x2,
  input  logic          ld_flushed,
  input  logic          blk_ready,
  output logic          free,
  output logic [DW-1:0] x3k,
  output logic [DW-1:0] x3k1,
  output logic [DW-1:0] x3k2,
  output logic          blk_valid,
  output logic          blk_flushed
);

  assign free = !blk_valid || blk_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_valid   <= 1'b0;
      blk_flushed <= 1'b0;
      x3k         <= '0;
      x3k1        <= '0;
      x3k2        <= '0;
    end else if (load) begin
      // A load in the same cycle as a consume keeps blk_valid high.
      blk_valid   <= 1'b1;
      blk_flushed <= ld_flushed;
      x3k         <= ld_x0;
      x3k1        <= ld_x1;
      x3k2        <= ld_x2;
    end else if (blk_ready) begin
      blk_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fir3x_s2p.sv
// Serial-to-parallel front end: groups 3 consecutive samples into one block for a 3x-unrolled FIR.
// Latency: block valid 1 cycle after its 3rd sample is accepted; 1 sample/cycle with blk_ready high.
// Backpressure: s_ready drops only when the 3rd sample has nowhere to go, or while a flush pad is pending.
// Ports: s_data/s_valid/s_ready (serial in), flush (terminate partial block), x3k/x3k1/x3k2/
//        blk_valid/blk_ready/blk_flushed (block out), fill (samples staged, 0..2).
// Build option FIR3X_FLUSH_PAD_EN: flush emits the partial block zero-padded; otherwise it is dropped.
module fir3x_s2p
  import fir3x_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          flush,
  output logic [DW-1:0] x3k,
  output logic [DW-1:0] x3k1,
  output logic [DW-1:0] x3k2,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic          blk_flushed,
  output logic [1:0]    fill
);

  fill_t         fill_q, fill_acc, fill_d;
  logic [DW-1:0] c0, c1;
  logic          flush_pend;
  logic          acc, blk_free, load, ld_flushed;
  logic [DW-1:0] ld_x0, ld_x1, ld_x2;

  assign acc     = s_valid && s_ready;
  assign s_ready = !(fill_q == FILL_2 && !blk_free) && !flush_pend;
  assign fill    = fill_q;

  // Fill level once this cycle's accepted sample is counted; flush acts on this.
  assign fill_acc = acc ? fill_next(fill_q) : fill_q;

`ifdef FIR3X_FLUSH_PAD_EN
  logic pend_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_pend <= 1'b0;
    else       flush_pend <= pend_d;
  end
`else
  assign flush_pend = 1'b0;
`endif

  always_comb begin
    fill_d     = fill_acc;
    load       = 1'b0;
    ld_flushed = 1'b0;
    ld_x0      = c0;
    ld_x1      = c1;
    ld_x2      = s_data;
`ifdef FIR3X_FLUSH_PAD_EN
    pend_d     = flush_pend;
`endif
    if (acc && fill_q == FILL_2) begin
      // s_ready guarantees the output register is free here.
      load = 1'b1;
`ifdef FIR3X_FLUSH_PAD_EN
    end else if (flush_pend) begin
      // No sample can arrive while pending, so fill_q is the partial block size.
      if (blk_free) begin
        load       = 1'b1;
        ld_flushed = 1'b1;
        ld_x1      = (fill_q == FILL_2) ? c1 : '0;
        ld_x2      = '0;
        fill_d     = FILL_0;
        pend_d     = 1'b0;
      end
    end else if (flush && fill_acc != FILL_0) begin
      pend_d = 1'b1;
`else
    end else if (flush && fill_acc != FILL_0) begin
      fill_d = FILL_0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= FILL_0;
      c0     <= '0;
      c1     <= '0;
    end else begin
      fill_q <= fill_d;
      if (acc && fill_q == FILL_0) c0 <= s_data;
      if (acc && fill_q == FILL_1) c1 <= s_data;
    end
  end

  fir3x_blk_reg #(.DW(DW)) u_blk_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .ld_x0       (ld_x0),
    .ld_x1       (ld_x1),
    .ld_x2       (ld_x2),
    .ld_flushed  (ld_flushed),
    .blk_ready   (blk_ready),
    .free        (blk_free),
    .x3k         (x3k),
    .x3k1        (x3k1),
    .x3k2        (x3k2),
    .blk_valid   (blk_valid),
    .blk_flushed (blk_flushed)
  );

endmodule

// File: tb/tb_fir3x_s2p.sv
// Self-checking bench for fir3x_s2p: directed scenarios followed by random traffic,
// all compared each cycle against a sample-queue reference model.
module tb_fir3x_s2p;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        flush = 1'b0;
  logic [31:0] x3k, x3k1, x3k2;
  logic        blk_valid;
  logic        blk_ready = 1'b0;
  logic        blk_flushed;
  logic [1:0]  fill;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: samples waiting for a block, the block on the output, pad pending.
  logic [31:0] part[$];
  logic        m_valid, m_flushed, m_pend;
  logic [31:0] m_x0, m_x1, m_x2;

  fir3x_s2p dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .flush       (flush),
    .x3k         (x3k),
    .x3k1        (x3k1),
    .x3k2        (x3k2),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_flushed (blk_flushed),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_valid   = 1'b0;
    m_flushed = 1'b0;
    m_pend    = 1'b0;
    m_x0      = '0;
    m_x1      = '0;
    m_x2      = '0;
  endtask

  function automatic logic exp_ready();
    return !(part.size() == 2 && m_valid && !blk_ready) && !m_pend;
  endfunction

  task automatic compare_all();
    chk("s_ready", 32'(s_ready), 32'(exp_ready()));
    chk("fill", 32'(fill), 32'(part.size()));
    chk("blk_valid", 32'(blk_valid), 32'(m_valid));
    if (m_valid) begin
      chk("blk_flushed", 32'(blk_flushed), 32'(m_flushed));
      chk("x3k", x3k, m_x0);
      chk("x3k1", x3k1, m_x1);
      chk("x3k2", x3k2, m_x2);
    end
  endtask

  // Advance the model across one rising edge using the inputs seen before it.
  task automatic model_edge(input logic v, input logic [31:0] d, input logic f, input logic br);
    logic acc, free, loaded;
    acc    = v && exp_ready();
    free   = !m_valid || br;
    loaded = 1'b0;
    if (m_pend) begin
      if (free) begin
        m_x0      = part[0];
        m_x1      = (part.size() > 1) ? part[1] : 32'h0;
        m_x2      = 32'h0;
        m_flushed = 1'b1;
        part.delete();
        m_pend    = 1'b0;
        loaded    = 1'b1;
      end
    end else begin
      if (acc) part.push_back(d);
      if (part.size() == 3) begin
        m_x0      = part[0];
        m_x1      = part[1];
        m_x2      = part[2];
        m_flushed = 1'b0;
        part.delete();
        loaded    = 1'b1;
      end else if (f && part.size() > 0) begin
`ifdef FIR3X_FLUSH_PAD_EN
        m_pend = 1'b1;
`else
        part.delete();
`endif
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (m_valid && br) m_valid = 1'b0;
  endtask

  // Called at a falling edge: apply inputs, check, cross the rising edge, return at next falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic f, input logic br);
    s_valid   = v;
    s_data    = d;
    flush     = f;
    blk_ready = br;
    #1;
    compare_all();
    @(posedge clk);
    model_edge(v, d, f, br);
    @(negedge clk);
  endtask

  initial begin
    model_reset();

    // Reset state
    #2;
    chk("rst_blk_valid", 32'(blk_valid), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_x3k", x3k, 32'h0);
    chk("rst_blk_flushed", 32'(blk_flushed), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Streaming with blk_ready held high
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b1);
      if (i == 3) begin
        chk("stream_a_x3k", x3k, 32'd1);
        chk("stream_a_x3k1", x3k1, 32'd2);
        chk("stream_a_x3k2", x3k2, 32'd3);
      end
    end
    chk("stream_b_x3k", x3k, 32'd4);
    chk("stream_b_x3k2", x3k2, 32'd6);
    chk("stream_b_valid", 32'(blk_valid), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Backpressure
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("bp_fill", 32'(fill), 32'd2);
    chk("bp_s_ready", 32'(s_ready), 32'h0);
    chk("bp_held_x3k", x3k, 32'd1);
    chk("bp_held_x3k2", x3k2, 32'd3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bp_release_s_ready", 32'(s_ready), 32'h1);
    step(1'b1, 32'd6, 1'b0, 1'b1);
    chk("bp_b_x3k", x3k, 32'd4);
    chk("bp_b_x3k1", x3k1, 32'd5);
    chk("bp_b_x3k2", x3k2, 32'd6);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush of a two-sample partial block
    step(1'b1, 32'd7, 1'b0, 1'b1);
    step(1'b1, 32'd8, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FIR3X_FLUSH_PAD_EN
    chk("flush_valid", 32'(blk_valid), 32'h1);
    chk("flush_x3k", x3k, 32'd7);
    chk("flush_x3k1", x3k1, 32'd8);
    chk("flush_x3k2", x3k2, 32'd0);
    chk("flush_flushed", 32'(blk_flushed), 32'h1);
`else
    chk("flush_valid", 32'(blk_valid), 32'h0);
    chk("flush_flushed", 32'(blk_flushed), 32'h0);
`endif
    chk("flush_fill", 32'(fill), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Third sample accepted together with flush completes a normal block
    step(1'b1, 32'd10, 1'b0, 1'b1);
    step(1'b1, 32'd11, 1'b0, 1'b1);
    step(1'b1, 32'd9, 1'b1, 1'b1);
    chk("simul_x3k", x3k, 32'd10);
    chk("simul_x3k1", x3k1, 32'd11);
    chk("simul_x3k2", x3k2, 32'd9);
    chk("simul_flushed", 32'(blk_flushed), 32'h0);
    chk("simul_fill", 32'(fill), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    step(1'b1, 32'd20, 1'b0, 1'b1);
    step(1'b1, 32'd21, 1'b0, 1'b1);
    step(1'b1, 32'd22, 1'b0, 1'b1);
    step(1'b1, 32'd23, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(blk_valid), 32'h1);
    chk("pre_rst_fill", 32'(fill), 32'd1);
    s_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(blk_valid), 32'h0);
    chk("arst_fill", 32'(fill), 32'd0);
    chk("arst_x3k", x3k, 32'h0);
    chk("arst_x3k2", x3k2, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_s_ready", 32'(s_ready), 32'h1);

    // Signed extremes pass through bit-exact
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("ext_x3k", x3k, 32'h8000_0000);
    chk("ext_x3k1", x3k1, 32'h7FFF_FFFF);
    chk("ext_x3k2", x3k2, 32'hFFFF_FFFF);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0, ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
